// File: rtl/velocity_cell_pingpong.sv
// rtl/velocity_cell_pingpong.sv - double-buffered per-cell velocity store with append shadow bank
module velocity_cell_pingpong #(
    parameter int COMP_WIDTH   = 32,
    parameter int DATA_WIDTH   = 3 * COMP_WIDTH,
    parameter int PARTICLE_NUM = 220,
    parameter int ADDR_WIDTH   = 8,
    parameter int CNT_WIDTH    = ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  rd_oob,
    output logic [CNT_WIDTH-1:0]  active_count,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [CNT_WIDTH-1:0]  wr_count,
    output logic                  wr_full,
    output logic                  wr_overflow,
    input  logic                  swap,
    output logic                  active_bank
);

    localparam logic [CNT_WIDTH-1:0] FULL_COUNT = CNT_WIDTH'(PARTICLE_NUM);
    localparam logic [CNT_WIDTH-1:0] ONE_COUNT  = CNT_WIDTH'(1);

    // Bank storage; contents are never cleared, the counts gate visibility.
    logic [DATA_WIDTH-1:0] bank0_mem [0:PARTICLE_NUM-1];
    logic [DATA_WIDTH-1:0] bank1_mem [0:PARTICLE_NUM-1];
    logic [DATA_WIDTH-1:0] bank0_dout;
    logic [DATA_WIDTH-1:0] bank1_dout;

    logic                  active_bank_q,  active_bank_d;
    logic [CNT_WIDTH-1:0]  active_count_q, active_count_d;
    logic [CNT_WIDTH-1:0]  wr_count_q,     wr_count_d;
    logic                  wr_overflow_q,  wr_overflow_d;
    logic                  rd_valid_q,     rd_valid_d;
    logic                  rd_oob_q,       rd_oob_d;
    logic                  rd_zero_q,      rd_zero_d;
    logic                  rd_sel_q,       rd_sel_d;

    logic                  wr_full_c;
    logic                  wr_accept;
    logic                  rd_in_range;
    logic                  rd_hit;
    logic [CNT_WIDTH-1:0]  rd_addr_ext;
    logic [CNT_WIDTH-1:0]  fill_count;
    logic [ADDR_WIDTH-1:0] wr_idx;

    // Next-state logic for counters, bank select and read-side flags.
    always_comb begin
        wr_full_c   = (wr_count_q == FULL_COUNT);
        wr_accept   = wr_en && !wr_full_c && !rst;
        fill_count  = wr_accept ? (wr_count_q + ONE_COUNT) : wr_count_q;
        wr_idx      = wr_count_q[ADDR_WIDTH-1:0];
        rd_addr_ext = CNT_WIDTH'(rd_addr);
        rd_in_range = (rd_addr_ext < active_count_q);
        rd_hit      = rd_en && rd_in_range && !rst;

        active_bank_d  = active_bank_q;
        active_count_d = active_count_q;
        wr_count_d     = fill_count;
        wr_overflow_d  = wr_overflow_q;
        rd_valid_d     = rd_en;
        rd_oob_d       = rd_en && !rd_in_range;
        rd_zero_d      = rd_zero_q;
        rd_sel_d       = rd_sel_q;

        // A read remembers which bank it hit so the output mux follows it
        // even if a swap lands in the same cycle.
        if (rd_en) begin
            rd_zero_d = !rd_in_range;
            rd_sel_d  = active_bank_q;
        end

        if (wr_en && wr_full_c) begin
            wr_overflow_d = 1'b1;
        end

        // The write accepted in the swap cycle belongs to the outgoing shadow.
        if (swap) begin
            active_bank_d  = ~active_bank_q;
            active_count_d = fill_count;
            wr_count_d     = '0;
            wr_overflow_d  = 1'b0;
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            active_bank_q  <= 1'b0;
            active_count_q <= '0;
            wr_count_q     <= '0;
            wr_overflow_q  <= 1'b0;
            rd_valid_q     <= 1'b0;
            rd_oob_q       <= 1'b0;
            rd_zero_q      <= 1'b1;
            rd_sel_q       <= 1'b0;
        end else begin
            active_bank_q  <= active_bank_d;
            active_count_q <= active_count_d;
            wr_count_q     <= wr_count_d;
            wr_overflow_q  <= wr_overflow_d;
            rd_valid_q     <= rd_valid_d;
            rd_oob_q       <= rd_oob_d;
            rd_zero_q      <= rd_zero_d;
            rd_sel_q       <= rd_sel_d;
        end
    end

    // Bank 0 RAM: written while shadow, read while active.
    always_ff @(posedge clk) begin
        if (wr_accept && active_bank_q) begin
            bank0_mem[wr_idx] <= wr_data;
        end
        if (rd_hit && !active_bank_q) begin
            bank0_dout <= bank0_mem[rd_addr];
        end
    end

    // Bank 1 RAM: written while shadow, read while active.
    always_ff @(posedge clk) begin
        if (wr_accept && !active_bank_q) begin
            bank1_mem[wr_idx] <= wr_data;
        end
        if (rd_hit && active_bank_q) begin
            bank1_dout <= bank1_mem[rd_addr];
        end
    end

    // Output mux; zero flag covers both out-of-range reads and post-reset.
    always_comb begin
        rd_data = '0;
        if (!rd_zero_q) begin
            rd_data = rd_sel_q ? bank1_dout : bank0_dout;
        end
    end

    assign rd_valid     = rd_valid_q;
    assign rd_oob       = rd_oob_q;
    assign active_count = active_count_q;
    assign active_bank  = active_bank_q;
    assign wr_count     = wr_count_q;
    assign wr_full      = wr_full_c;
    assign wr_overflow  = wr_overflow_q;

endmodule
